// File: rtl/psc_timer_ctrl_if.sv
// Configuration channel of the prescaler timebase controller.
// Handshake: a transfer happens on a rising clk_in edge where cfg_valid && cfg_ready; the requester holds cfg_valid/cfg_div/cfg_oneshot stable until then.
interface psc_timer_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_oneshot;

  modport master (
    output cfg_valid,
    output cfg_div,
    output cfg_oneshot,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    input  cfg_oneshot,
    output cfg_ready
  );
endinterface

// File: rtl/psc_timer_ctrl.sv
// Run/stop sequencer for the prescaler timebase: programmable divisor, periodic or one-shot,
// emits a one-cycle enable tick and a square wave that toggles on every tick.
module psc_timer_ctrl #(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 50_000_000 - 1
) (
  input  logic                 clk_in,
  input  logic                 reset,
  psc_timer_ctrl_if.slave      cfg,
  input  logic                 start,
  input  logic                 stop,
  output logic                 tick,
  output logic                 sq_out,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     count,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             oneshot_q, oneshot_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             done_q, done_d;
  logic             cfg_xfer;

  assign cfg.cfg_ready = (state_q != ST_RUN);
  assign cfg_xfer      = cfg.cfg_valid && cfg.cfg_ready;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      div_q     <= CNT_W'(DEFAULT_DIV);
      oneshot_q <= 1'b0;
      tick_q    <= 1'b0;
      sq_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      div_q     <= div_d;
      oneshot_q <= oneshot_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    div_d     = div_q;
    oneshot_d = oneshot_q;
    tick_d    = 1'b0;
    sq_d      = sq_q;
    done_d    = done_q;

    // Config lands on the same edge as a start, so a freshly loaded divisor governs that run.
    if (cfg_xfer) begin
      div_d     = cfg.cfg_div;
      oneshot_d = cfg.cfg_oneshot;
      done_d    = 1'b0;
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          count_d = '0;
          sq_d    = 1'b0;
          done_d  = 1'b0;
        end
      end
      ST_RUN: begin
        // stop wins over a coincident terminal count: no tick, square wave frozen.
        if (stop) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (count_q == div_q) begin
          count_d = '0;
          tick_d  = 1'b1;
          sq_d    = ~sq_q;
          if (oneshot_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tick      = tick_q;
  assign sq_out    = sq_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign count     = count_q;
  assign dbg_state = state_q;

endmodule

// File: doc/psc_timer_ctrl.md
Name: psc_timer_ctrl

Overview:
- Run/stop sequencer and configuration front-end for the prescaler timebase.
- Holds a programmable divisor loaded via a valid/ready handshake.
- Sequences counting in periodic or one-shot mode.
- Emits a single-cycle enable tick plus a toggling square output, replacing free-running derived clocks.
- Sits between the FSM control logic and any consumer needing a slow timebase in the clk_in domain.

Parameters:
CNT_W, 32, width of divisor and counter.
DEFAULT_DIV, 50_000_000-1, divisor value after reset; tick period = divisor+1 cycles.

Ports:
clk_in  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
cfg_valid  in  1  configuration request.
cfg_ready  out  1  controller can accept configuration.
cfg_div  in  CNT_W  divisor to load.
cfg_oneshot  in  1  1 = one-shot, 0 = periodic.
start  in  1  start request, sampled per edge.
stop  in  1  stop request, sampled per edge.
tick  out  1  one-cycle pulse per completed period.
sq_out  out  1  toggles on every tick.
busy  out  1  high while counting.
done  out  1  one-shot completed (sticky).
count  out  CNT_W  current counter value.

Behaviour:
- Reset (reset=0, async): state=IDLE, count=0, tick=0, sq_out=0, done=0, busy=0, div_q=DEFAULT_DIV, oneshot_q=0. cfg_ready=1 (decoded from state).
- States: IDLE, RUN, DONE. busy = (state==RUN). cfg_ready = (state!=RUN), combinational.
- Config handshake:
  - Transfer on an edge where cfg_valid && cfg_ready: div_q<=cfg_div, oneshot_q<=cfg_oneshot, done<=0.
  - In RUN, cfg_ready=0; the requester holds cfg_valid until accepted.
  - cfg_div=0 is legal and gives a tick every cycle.
- IDLE/DONE + start=1 (stop=0):
  - Next state RUN; count<=0, sq_out<=0, done<=0.
  - If a config transfer occurs on the same edge, the new div_q/oneshot_q apply to this run.
- RUN counting:
  - count increments by 1 per edge.
  - On the edge where count==div_q: count<=0, tick<=1 (registered, high exactly one cycle), sq_out<=~sq_out.
  - Otherwise tick<=0.
  - First tick is high during cycle div_q+1 after the start edge; subsequent ticks every div_q+1 cycles.
  - Counter compare is unsigned, CNT_W bits; no overflow possible since count never exceeds div_q.
- One-shot: on the terminal edge, tick<=1, state<=DONE, done<=1. done holds until start or a config transfer.
- Periodic: stays in RUN indefinitely.
- stop=1 in RUN:
  - Next state IDLE, count<=0, tick<=0; sq_out holds its value.
  - stop beats a coincident terminal count (no tick, no toggle).
  - stop beats a coincident start.
- start in RUN is ignored (no restart).
- stop in IDLE/DONE has no effect.
- reset asserted mid-run: all outputs return to reset values immediately; no pending tick survives.

Test Plan:
- Release reset; cfg_div=3, cfg_oneshot=0 with cfg_valid → accepted (cfg_ready=1). Pulse start → tick high every 4 cycles, first at cycle 4 after the start edge; sq_out toggles per tick; busy=1.
- cfg_div=2, oneshot=1, start → single tick at cycle 3, then state DONE, done=1, busy=0, count=0. No further ticks over 20 cycles.
- During periodic RUN (div=5) assert cfg_valid with cfg_div=9 → cfg_ready=0, period stays 6. Assert stop → IDLE, cfg accepted next edge. Start → period 10.
- Periodic div=4: assert stop on the edge where count==4 → no tick, no sq_out toggle, IDLE next cycle. Assert start and stop together in IDLE → remains IDLE.
- cfg_div=0, periodic, start → tick continuously high (one pulse per cycle); sq_out toggles every cycle.
- Mid-run, drive reset=0 between edges → tick, sq_out, busy, count drop to 0 asynchronously; div_q reads back DEFAULT_DIV behaviour (50,000,000-cycle period) after the next start.
